// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock, registered round-key reads.
// Define INV_ORDER_EN to add rd_inv (read round keys in decryption order).
module aes_key_expand_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic                rd_en,
  input  logic [3:0]          rd_rnd,
`ifdef INV_ORDER_EN
  input  logic                rd_inv,
`endif
  output logic [127:0]        rd_key,
  output logic                rd_valid
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]],
            SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  mod_q, mod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        kv_q, kv_d;
  logic        load, wr;

  logic [31:0] w_q [NW];

  logic [31:0] prev_w, back_w, sub_in, sub_out, t_w, new_w;
  logic [7:0]  rcon_nx;

  always_comb begin
    prev_w  = w_q[cnt_q - 6'd1];
    back_w  = w_q[cnt_q - 6'(NK)];
    sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    if (mod_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && mod_q == 3'd4) begin
      t_w = sub_out;
    end else begin
      t_w = prev_w;
    end
    new_w   = back_w ^ t_w;
    rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    kv_d    = kv_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = GEN;
          cnt_d   = 6'(NK);
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          kv_d    = 1'b0;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GEN: begin
        wr    = 1'b1;
        cnt_d = cnt_q + 6'd1;
        mod_d = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) begin
          rcon_d = rcon_nx;
        end
        if (cnt_q == 6'(NW - 1)) begin
          state_d = DONE;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      mod_q   <= 3'd0;
      rcon_q  <= 8'h01;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      kv_q    <= kv_d;
    end
  end

  // Schedule storage survives reset; keys_valid tells consumers when it is usable.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < NK; j++) begin
        w_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
      end
    end else if (wr) begin
      w_q[cnt_q] <= new_w;
    end
  end

  assign busy       = (state_q == GEN);
  assign done       = (state_q == DONE);
  assign keys_valid = kv_q;

  logic         rnd_ok;
  logic [3:0]   eff;
  logic [5:0]   base;
  logic [127:0] rd_d;
  logic [127:0] rd_key_q;
  logic         rd_valid_q;

  // Range check uses the raw index; out-of-range reads return zero.
  always_comb begin
    rnd_ok = (rd_rnd <= 4'(NR));
    eff    = rd_rnd;
`ifdef INV_ORDER_EN
    if (rd_inv) begin
      eff = 4'(NR) - rd_rnd;
    end
`endif
    if (!rnd_ok) begin
      eff = 4'd0;
    end
    base = {eff, 2'b00};
    rd_d = {w_q[base], w_q[base + 6'd1],
            w_q[base + 6'd2], w_q[base + 6'd3]};
    if (!rnd_ok) begin
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_key_q <= rd_d;
      end
    end
  end

  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Iterative AES key-expansion engine for AES-128/192/256, selected by parameter.
- Generates one 32-bit schedule word per clock and stores the full schedule internally.
- Round keys are served through a registered read port.
- Sits between the key-load interface and the round datapath. Replaces per-round combinational key derivation, so the cipher core can fetch any round key by index, in any order.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128, 192, 256; any other value is a compile-time error.
NK (local), KEY_BITS/32, key length in words: 4, 6 or 8.
NR (local), NK+6, number of rounds: 10, 12 or 14.
NW (local), 4*(NR+1), total schedule words: 44, 52 or 60.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; samples key_in and begins expansion.
key_in  in  KEY_BITS  cipher key; byte 0 = key_in[KEY_BITS-1 -: 8]; word 0 = key_in[KEY_BITS-1 -: 32].
busy  out  1  high while schedule words are being generated.
done  out  1  one-cycle pulse when expansion completes.
keys_valid  out  1  level; the full schedule is valid and readable.
rd_en  in  1  round-key read request.
rd_rnd  in  4  round index, 0..NR.
rd_key  out  128  round key rd_rnd; words w[4r]..w[4r+3], w[4r] in [127:96].
rd_valid  out  1  high one cycle after rd_en; qualifies rd_key.

Behaviour:
- Reset values: busy=0, done=0, keys_valid=0, rd_valid=0, rd_key=0, word counter=0, rcon register=8'h01. Word storage is not cleared.
- States are IDLE, GEN and DONE.
- IDLE -> GEN: on start. In the same edge, key_in is written to w[0..NK-1], counter i=NK, rcon=01, keys_valid cleared.
- GEN, each cycle: compute w[i] = w[i-NK] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod NK == 0;
  - t = SubWord(w[i-1]) when NK==8 and i mod 8 == 4;
  - t = w[i-1] otherwise.
- RotWord rotates the most-significant byte to the least-significant position.
- Rcon is updated by xtime (shift left, XOR 8'h1b on carry) after each use; no lookup table.
- Only 4 S-box instances exist (one word per cycle).
- GEN -> DONE when i == NW-1 is written. Generation takes NW-NK cycles: 40, 46 or 52.
- DONE: done=1 for exactly one cycle, keys_valid=1, busy=0, then return to IDLE. keys_valid holds until the next accepted start or rst.
- start while busy: ignored; no restart.
- start in the DONE cycle: accepted as in IDLE.
- Reads are independent of the FSM. rd_en at edge N gives rd_key and rd_valid at edge N+1.
- rd_rnd > NR: rd_key=0, rd_valid still asserted.
- Reads while keys_valid=0 return stale storage; the consumer must gate reads on keys_valid.
- rst mid-GEN: returns to IDLE next edge with all outputs at reset values. A subsequent start restarts cleanly, with rcon reinitialised.

Optional Feature:
- Macro INV_ORDER_EN adds input port rd_inv (1 bit).
- With INV_ORDER_EN defined: when rd_inv=1 the effective index is NR-rd_rnd (decryption order); the range check is applied to rd_rnd before inversion.
- Without it: port absent, index always rd_rnd.
- All other behaviour is identical.

Test Plan:
1. KEY_BITS=128, start with key 2b7e151628aed2a6abf7158809cf4f3c:
   - busy for 40 cycles, then done pulses for 1 cycle;
   - read rnd 1 -> a0fafe1788542cb123a339392a6c7605;
   - read rnd 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - 46 busy cycles;
   - read rnd 12 -> e98ba06f448c773c8ecc720401002202.
3. KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - 52 busy cycles;
   - read rnd 14 -> fe4890d1e6188d0b046df344706c631e;
   - rnd 0 -> 603deb1015ca71be2b73aef0857d7781.
4. Assert start again at cycle 10 of GEN -> ignored; completion timing and key values identical to scenario 1.
5. rst at cycle 20 of GEN, then start with the scenario-1 key -> outputs at reset values after rst; full 40-cycle run; rnd 10 key correct (checks rcon reinit).
6. Read rd_rnd=11 with KEY_BITS=128 -> rd_valid=1, rd_key=0. With INV_ORDER_EN: rd_inv=1, rd_rnd=0 -> round-10 key from scenario 1.
